// File: rtl/reg_sequencer_pkg.sv
// Shared encodings for the register command sequencer: op codes, FSM states
// and small op-classification helpers.
package reg_sequencer_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_CLR  = 3'd0;
    localparam logic [OP_W-1:0] OP_LOAD = 3'd1;
    localparam logic [OP_W-1:0] OP_INC  = 3'd2;
    localparam logic [OP_W-1:0] OP_DEC  = 3'd3;
    localparam logic [OP_W-1:0] OP_SHR  = 3'd4;
    localparam logic [OP_W-1:0] OP_SHL  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Ops that honour the repeat count.
    function automatic logic op_is_repeat(input logic [OP_W-1:0] op);
        return (op == OP_INC) || (op == OP_DEC) || (op == OP_SHR) || (op == OP_SHL);
    endfunction

    // Codes 6 and 7 complete without issuing any strobe.
    function automatic logic op_is_nop(input logic [OP_W-1:0] op);
        return op > OP_SHL;
    endfunction

endpackage

// File: rtl/reg_sequencer.sv
// Expands one accepted command into consecutive single-cycle register strobes,
// then pulses done once the register output holds the final value.
module reg_sequencer
    import reg_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [OP_W-1:0]       cmd_op,
    input  logic [CNT_WIDTH-1:0]  cmd_count,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    input  logic                  cmd_fill,
    output logic                  cl,
    output logic                  ld,
    output logic                  inc,
    output logic                  dec,
    output logic                  sr,
    output logic                  sl,
    output logic [DATA_WIDTH-1:0] in,
    output logic                  ir,
    output logic                  il,
    output logic                  busy,
    output logic                  done
);

    state_t                  state_q, state_next;
    logic [OP_W-1:0]         op_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    fill_q;
    logic [CNT_WIDTH-1:0]    rem_q;
    logic                    accept;

    assign accept = (state_q == ST_IDLE) && cmd_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_CLR;
            data_q  <= '0;
            fill_q  <= 1'b0;
            rem_q   <= '0;
        end else begin
            state_q <= state_next;
            if (accept) begin
                op_q   <= cmd_op;
                data_q <= cmd_data;
                fill_q <= cmd_fill;
                rem_q  <= cmd_count;
            end else if (state_q == ST_RUN) begin
                rem_q <= rem_q - CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        state_next = state_q;
        cmd_ready  = 1'b0;
        done       = 1'b0;
        cl         = 1'b0;
        ld         = 1'b0;
        inc        = 1'b0;
        dec        = 1'b0;
        sr         = 1'b0;
        sl         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    // Zero-strobe commands skip RUN so done lands one cycle after accept.
                    if (op_is_nop(cmd_op) || (op_is_repeat(cmd_op) && cmd_count == '0))
                        state_next = ST_DONE;
                    else
                        state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                case (op_q)
                    OP_CLR:  cl  = 1'b1;
                    OP_LOAD: ld  = 1'b1;
                    OP_INC:  inc = 1'b1;
                    OP_DEC:  dec = 1'b1;
                    OP_SHR:  sr  = 1'b1;
                    OP_SHL:  sl  = 1'b1;
                    default: ;
                endcase
                if (!op_is_repeat(op_q) || rem_q == CNT_WIDTH'(1))
                    state_next = ST_DONE;
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign busy = (state_q != ST_IDLE);
    assign in   = data_q;
    assign ir   = fill_q;
    assign il   = fill_q;

endmodule

// File: tb/tb_reg_sequencer.sv
// Directed bench: drives commands into reg_sequencer, models the downstream
// register, and scoreboards strobe counts, done timing and final register value.
module tb_reg_sequencer;
    import reg_sequencer_pkg::*;

    localparam int DW = 16;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [CW-1:0] cmd_count;
    logic [DW-1:0] cmd_data;
    logic          cmd_fill;
    logic          cl, ld, inc, dec, sr, sl;
    logic [DW-1:0] in;
    logic          ir, il, busy, done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [DW-1:0] val;
        int            n;
        logic [5:0]    mask;
    } exp_t;
    exp_t sb[$];

    logic [DW-1:0] reg_val;

    always #5 clk = ~clk;

    reg_sequencer #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_count(cmd_count), .cmd_data(cmd_data), .cmd_fill(cmd_fill),
        .cl(cl), .ld(ld), .inc(inc), .dec(dec), .sr(sr), .sl(sl),
        .in(in), .ir(ir), .il(il), .busy(busy), .done(done)
    );

    // Behavioural model of the downstream register.
    always_ff @(posedge clk) begin
        if (cl)       reg_val <= '0;
        else if (ld)  reg_val <= in;
        else if (inc) reg_val <= reg_val + 16'd1;
        else if (dec) reg_val <= reg_val - 16'd1;
        else if (sr)  reg_val <= {ir, reg_val[DW-1:1]};
        else if (sl)  reg_val <= {reg_val[DW-2:0], il};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input string tag, input logic [2:0] op, input logic [CW-1:0] cnt,
                           input logic [DW-1:0] data, input logic fill,
                           input logic [DW-1:0] exp_val, input int exp_n, input bit hold);
        exp_t e;
        int good, bad, rdy, cont_bad, nbusy, done_cyc;
        logic [5:0] strobes;
        logic [DW-1:0] final_val;
        e.val  = exp_val;
        e.n    = exp_n;
        e.mask = (op <= OP_SHL) ? (6'd1 << op) : 6'd0;
        @(negedge clk);
        chk({tag, "_ready_before"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_count = cnt;
        cmd_data  = data;
        cmd_fill  = fill;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (hold) begin
            cmd_op    = OP_CLR;
            cmd_count = 4'd5;
            cmd_data  = 16'hDEAD;
            cmd_fill  = ~fill;
        end else begin
            cmd_valid = 1'b0;
        end
        good = 0; bad = 0; rdy = 0; cont_bad = 0; nbusy = 0; done_cyc = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done) begin
                done_cyc = c;
                break;
            end
            strobes = {sl, sr, dec, inc, ld, cl};
            if (strobes == e.mask && e.mask != 6'd0) good++;
            else if (strobes != 6'd0) bad++;
            if (cmd_ready) rdy++;
            if (!busy) nbusy++;
            if (in !== data || ir !== fill || il !== fill) cont_bad++;
        end
        cmd_valid = 1'b0;
        final_val = reg_val;
        chk({tag, "_done_strobes"}, 32'({sl, sr, dec, inc, ld, cl}), 32'd0);
        chk({tag, "_done_ready"}, 32'(cmd_ready), 32'd0);
        if (sb.size() == 0) begin
            chk({tag, "_scoreboard_empty"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_done_cycle"}, 32'(done_cyc), 32'(e.n + 1));
            chk({tag, "_strobe_count"}, 32'(good), 32'(e.n));
            chk({tag, "_wrong_strobes"}, 32'(bad), 32'd0);
            chk({tag, "_ready_while_busy"}, 32'(rdy), 32'd0);
            chk({tag, "_busy_low"}, 32'(nbusy), 32'd0);
            chk({tag, "_in_ir_il"}, 32'(cont_bad), 32'd0);
            chk({tag, "_reg_value"}, 32'(final_val), 32'(e.val));
        end
        @(negedge clk);
        chk({tag, "_done_after"}, 32'(done), 32'd0);
        chk({tag, "_ready_after"}, 32'(cmd_ready), 32'd1);
        $display("cmd %s op=%0d cnt=%0d data=%h fill=%0d -> reg=%h done_cycle=%0d strobes=%0d",
                 tag, op, cnt, data, fill, final_val, done_cyc, good);
    endtask

    initial begin
        int n_sr, n_any;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_count = '0;
        cmd_data  = '0;
        cmd_fill  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", 32'(cmd_ready), 32'd1);
        chk("reset_strobes", 32'({cl, ld, inc, dec, sr, sl}), 32'd0);
        chk("reset_busy_done", 32'({busy, done}), 32'd0);
        chk("reset_in_ir_il", 32'({in, ir, il}), 32'd0);
        $display("reset: ready=%0d busy=%0d done=%0d in=%h", cmd_ready, busy, done, in);

        run_cmd("load1234", OP_LOAD, 4'd0, 16'h1234, 1'b0, 16'h1234, 1, 1'b0);
        run_cmd("load00ff", OP_LOAD, 4'd7, 16'h00FF, 1'b0, 16'h00FF, 1, 1'b0);
        run_cmd("inc3",     OP_INC,  4'd3, 16'h0000, 1'b0, 16'h0102, 3, 1'b0);
        run_cmd("reload",   OP_LOAD, 4'd0, 16'h1234, 1'b0, 16'h1234, 1, 1'b0);
        run_cmd("shl4",     OP_SHL,  4'd4, 16'h0000, 1'b1, 16'h234F, 4, 1'b0);
        run_cmd("shr1",     OP_SHR,  4'd1, 16'h0000, 1'b1, 16'h91A7, 1, 1'b0);
        run_cmd("clr",      OP_CLR,  4'd9, 16'h5555, 1'b0, 16'h0000, 1, 1'b0);
        run_cmd("dec1",     OP_DEC,  4'd1, 16'h0000, 1'b0, 16'hFFFF, 1, 1'b0);
        run_cmd("dec0",     OP_DEC,  4'd0, 16'h0000, 1'b0, 16'hFFFF, 0, 1'b0);
        run_cmd("nop6",     3'd6,    4'd5, 16'h0000, 1'b0, 16'hFFFF, 0, 1'b0);
        run_cmd("inc2_hold", OP_INC, 4'd2, 16'h0000, 1'b0, 16'h0001, 2, 1'b1);
        run_cmd("inc15",    OP_INC,  4'd15, 16'h0000, 1'b0, 16'h0010, 15, 1'b0);

        // Abort an 8-strobe shift after 3 strobes.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = OP_SHR;
        cmd_count = 4'd8;
        cmd_data  = 16'h0000;
        cmd_fill  = 1'b0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        n_sr = 0;
        repeat (3) begin
            @(negedge clk);
            if (sr) n_sr++;
        end
        chk("abort_sr_before", 32'(n_sr), 32'd3);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_strobes", 32'({cl, ld, inc, dec, sr, sl}), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ready", 32'(cmd_ready), 32'd1);
        chk("abort_done", 32'(done), 32'd0);
        rst = 1'b0;
        n_any = 0;
        repeat (10) begin
            @(negedge clk);
            if ({cl, ld, inc, dec, sr, sl} != 6'd0 || done) n_any++;
        end
        chk("abort_quiet", 32'(n_any), 32'd0);
        $display("abort: sr_before=%0d activity_after=%0d", n_sr, n_any);

        run_cmd("post_abort_load", OP_LOAD, 4'd0, 16'hABCD, 1'b0, 16'hABCD, 1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
